jtdd_mcu_host: RTL and testbench
================================

# jtdd_mcu_host

Main-CPU-side controller for the Double Dragon 6801 MCU subsystem. It drives the MCU halt and NMI requests, latches the MCU-to-main interrupt and arbitrates main-CPU access to the 512-byte shared RAM against MCU bus ownership (`mcu_ban`). It inserts wait states on the main CPU and returns read data. It sits between the main CPU address decoder and the MCU block.

## Interface

Parameters:
- `NMI_LEN`, 4: length of the `mcu_nmi_set` pulse, in `cen` cycles (1–15).
- `WAIT_MAX`, 255: `cen` cycles allowed in WAIT before timeout (8-bit).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cen` in 1: main-CPU clock enable. All state advances only on `cen`.
- `cpu_AB` in 9: main-CPU address into the shared RAM window.
- `cpu_wrn` in 1: main-CPU write strobe, low = write.
- `cpu_dout` in 8: main-CPU write data.
- `cpu_din` out 8: read data returned to the main CPU.
- `cpu_waitn` out 1: main-CPU wait, low = stretch cycle.
- `com_cs` in 1: main CPU selects the shared RAM window.
- `ctrl_cs` in 1: control register write select.
- `nmi_cs` in 1: NMI trigger write select.
- `irqack_cs` in 1: main-IRQ acknowledge write select.
- `stat_cs` in 1: status register read select.
- `host_AB` out 9: shared RAM address.
- `host_dout` out 8: shared RAM write data.
- `host_we` out 1: shared RAM write enable.
- `shared_dout` in 8: shared RAM read data. The RAM is registered, with 1 `cen` latency.
- `mcu_ban` in 1: MCU currently owns the shared bus.
- `mcu_halt` out 1: halt request to the MCU.
- `mcu_nmi_set` out 1: NMI request pulse to the MCU.
- `mcu_irqmain` in 1: interrupt request from the MCU.
- `main_irq` out 1: latched interrupt to the main CPU.

## Operation

- **Control register:** on a `cen` with `ctrl_cs & !cpu_wrn`, `mcu_halt <= cpu_dout[0]`. Other bits are ignored.
- **NMI pulse:** on a `cen` with `nmi_cs & !cpu_wrn`, `mcu_nmi_set` goes high and a 4-bit counter loads `NMI_LEN`.
  - The counter decrements on each `cen`. The output drops when the counter reaches 0.
  - A new trigger during an active pulse reloads the counter; the pulse is extended, not doubled.
- **Main IRQ:** `mcu_irqmain` is sampled on each `cen`. A rising edge sets `main_irq`.
  - On a `cen` with `irqack_cs & !cpu_wrn`, `main_irq` clears.
  - If an edge and an ack occur on the same `cen`, set wins.
- **Status:** when `stat_cs` is high, `cpu_din = {5'b0, timeout, halt_ack, main_irq}`.
  - `halt_ack` = `mcu_halt & !mcu_ban`, registered on `cen`.
  - A status read (`stat_cs` high on a `cen`) clears `timeout`.
- **Shared RAM arbitration FSM** (states IDLE, WAIT, GRANT, READ, DONE):
  - **IDLE:** when `com_cs` is seen, go to WAIT if `mcu_ban`, otherwise to GRANT.
  - **WAIT:** count `cen` cycles. Go to GRANT on the first `cen` with `!mcu_ban`.
  - **GRANT:** drive `host_AB = cpu_AB`. Assert `host_we = !cpu_wrn` for exactly one `cen`, committed only if `mcu_ban` is low.
    - If `mcu_ban` is high, return to WAIT with nothing written.
    - Otherwise go to READ for a read, or DONE for a write.
  - **READ:** capture `shared_dout` into the data latch at the end of the `cen`, then go to DONE. If `mcu_ban` rises here, go back to WAIT.
  - **DONE:** hold until `com_cs` falls, then go to IDLE.
- `host_dout = cpu_dout` at all times. `host_we` is 0 outside GRANT.
- `cpu_waitn = !(com_cs & state ∈ {IDLE, WAIT, GRANT, READ})`. This is combinational, so wait is asserted in the same cycle `com_cs` appears.
- `cpu_din` is the data latch when `com_cs` is high, the status word when `stat_cs` is high, and `8'h00` otherwise.

## Timing

- Reset values: `mcu_halt` = 1 (the MCU is held halted until the main CPU releases it). All other outputs are 0, except `cpu_waitn` = 1. The FSM is in IDLE, and the latch and counters are 0.
- Uncontended read: `cpu_waitn` is low for 3 `cen` cycles (IDLE, GRANT, READ), and data is valid from the first DONE `cen`.
- Uncontended write: `cpu_waitn` is low for 2 `cen` cycles.
- Contended access: add 1 `cen` per WAIT cycle.
- `mcu_nmi_set` stays high for exactly `NMI_LEN` `cen` cycles after the trigger `cen`.
- `main_irq` rises 1 `cen` after the rising edge of `mcu_irqmain`.
- Reset asserted mid-access: the FSM returns to IDLE immediately and any pending write is dropped.

## Configuration

- `JTDD_MCU_HOST_TIMEOUT_EN` defined:
  - When the WAIT counter reaches `WAIT_MAX`, the FSM goes to DONE with the latch loaded with `8'hFF`, no write is performed, and `timeout` is set.
- Not defined:
  - WAIT lasts indefinitely, the counter is removed, and `timeout` is tied to 0.

## Test plan

- **Reset:** `rst_n` low, then high → `mcu_halt` = 1, `mcu_nmi_set` = 0, `main_irq` = 0, `cpu_waitn` = 1.
- **Uncontended read:** write 0x5A at shared address 0x123, then read 0x123 with `mcu_ban` = 0 → `cpu_waitn` low for 3 `cen`, `cpu_din` = 0x5A.
- **Contended write:** hold `mcu_ban` high for 10 `cen` while the main CPU writes 0x77 at 0x010 → no `host_we` while `mcu_ban` is high, exactly one `host_we` pulse after it drops, `cpu_waitn` low for 12 `cen`.
- **NMI retrigger:** with `NMI_LEN` = 4, write `nmi_cs`, then write it again 2 `cen` later → `mcu_nmi_set` high for 6 `cen` total.
- **IRQ set/ack collision:** an `irqack_cs` write on the same `cen` as the `mcu_irqmain` rising edge → `main_irq` stays 1. A second ack → `main_irq` = 0.
- **Timeout** (macro on, `WAIT_MAX` = 8): keep `mcu_ban` high and read → `cpu_din` = 0xFF and the status read returns bit 2 = 1. A second status read returns bit 2 = 0.

Source files
------------

// File: rtl/jtdd_mcu_host.sv
// jtdd_mcu_host: main-CPU side of the Double Dragon 6801 MCU link.
// Drives MCU halt/NMI, latches the MCU-to-main IRQ and arbitrates main-CPU
// access to the 512-byte shared RAM against MCU bus ownership (mcu_ban).
// Optional macro JTDD_MCU_HOST_TIMEOUT_EN: abort a WAIT after WAIT_MAX cen
// cycles, return 8'hFF and flag timeout in the status word.
module jtdd_mcu_host #(
    parameter int unsigned NMI_LEN  = 4,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic [8:0] cpu_AB,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic       cpu_waitn,
    input  logic       com_cs,
    input  logic       ctrl_cs,
    input  logic       nmi_cs,
    input  logic       irqack_cs,
    input  logic       stat_cs,
    output logic [8:0] host_AB,
    output logic [7:0] host_dout,
    output logic       host_we,
    input  logic [7:0] shared_dout,
    input  logic       mcu_ban,
    output logic       mcu_halt,
    output logic       mcu_nmi_set,
    input  logic       mcu_irqmain,
    output logic       main_irq
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_GRANT = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [3:0] NMI_LOAD = 4'(NMI_LEN);

    if (NMI_LEN < 1 || NMI_LEN > 15 || WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_param
        $error("jtdd_mcu_host: NMI_LEN must be 1..15 and WAIT_MAX 1..255");
    end

    logic [2:0] state_q, state_d;
    logic [7:0] latch_q, latch_d;
    logic       halt_q, halt_d;
    logic [3:0] nmi_cnt_q, nmi_cnt_d;
    logic       irq_last_q, irq_last_d;
    logic       main_irq_q, main_irq_d;
    logic       halt_ack_q, halt_ack_d;
    logic       wait_expire;
    logic       timeout;

`ifdef JTDD_MCU_HOST_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    // Expire on the WAIT_MAX-th WAIT cycle that still sees the bus banned
    assign wait_expire = (state_q == ST_WAIT) && mcu_ban && (wait_cnt_q == WAIT_LAST);
    assign timeout     = timeout_q;

    // WAIT cycle counter and sticky timeout flag (set beats status-read clear)
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (cen) begin
            wait_cnt_d = (state_q == ST_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
            if (stat_cs) timeout_d = 1'b0;
            if (wait_expire) timeout_d = 1'b1;
        end
    end

    // Timeout state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
`else
    assign wait_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Shared RAM arbitration and read-data latch
    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        if (cen) begin
            unique case (state_q)
                ST_IDLE:  if (com_cs) state_d = mcu_ban ? ST_WAIT : ST_GRANT;
                ST_WAIT: begin
                    if (!mcu_ban) begin
                        state_d = ST_GRANT;
                    end else if (wait_expire) begin
                        state_d = ST_DONE;
                        latch_d = 8'hFF;
                    end
                end
                ST_GRANT: begin
                    if (mcu_ban) state_d = ST_WAIT;
                    else         state_d = cpu_wrn ? ST_READ : ST_DONE;
                end
                ST_READ: begin
                    if (mcu_ban) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_DONE;
                        latch_d = shared_dout;
                    end
                end
                ST_DONE:  if (!com_cs) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Control, NMI pulse counter, IRQ edge latch and halt acknowledge
    always_comb begin
        halt_d     = halt_q;
        nmi_cnt_d  = nmi_cnt_q;
        irq_last_d = irq_last_q;
        main_irq_d = main_irq_q;
        halt_ack_d = halt_ack_q;
        if (cen) begin
            if (ctrl_cs && !cpu_wrn) halt_d = cpu_dout[0];
            // Retrigger reloads rather than stacks, so the pulse is extended
            if (nmi_cs && !cpu_wrn)      nmi_cnt_d = NMI_LOAD;
            else if (nmi_cnt_q != 4'd0)  nmi_cnt_d = nmi_cnt_q - 4'd1;
            irq_last_d = mcu_irqmain;
            if (mcu_irqmain && !irq_last_q)  main_irq_d = 1'b1;
            else if (irqack_cs && !cpu_wrn)  main_irq_d = 1'b0;
            halt_ack_d = halt_q && !mcu_ban;
        end
    end

    // State registers; the MCU comes out of reset halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            latch_q    <= 8'd0;
            halt_q     <= 1'b1;
            nmi_cnt_q  <= 4'd0;
            irq_last_q <= 1'b0;
            main_irq_q <= 1'b0;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            latch_q    <= latch_d;
            halt_q     <= halt_d;
            nmi_cnt_q  <= nmi_cnt_d;
            irq_last_q <= irq_last_d;
            main_irq_q <= main_irq_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    assign host_AB     = (state_q == ST_GRANT) ? cpu_AB : 9'd0;
    assign host_dout   = cpu_dout;
    assign host_we     = (state_q == ST_GRANT) && !cpu_wrn && !mcu_ban;
    assign cpu_waitn   = !(com_cs && (state_q != ST_DONE));
    assign cpu_din     = com_cs  ? latch_q :
                         stat_cs ? {5'b0, timeout, halt_ack_q, main_irq_q} : 8'h00;
    assign mcu_halt    = halt_q;
    assign mcu_nmi_set = (nmi_cnt_q != 4'd0);
    assign main_irq    = main_irq_q;

endmodule

// File: tb/tb_jtdd_mcu_host.sv
// Self-checking bench for jtdd_mcu_host: randomized shared-RAM accesses with
// random MCU bus contention, NMI pulses, IRQ set/ack and status reads, all
// checked against a transaction-level model of the host controller.
module tb_jtdd_mcu_host;

    localparam int unsigned NMI_LEN = 4;
    localparam int unsigned WMAX    = 8;
`ifdef JTDD_MCU_HOST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic [8:0] cpu_AB = 9'd0;
    logic       cpu_wrn = 1'b1;
    logic [7:0] cpu_dout = 8'd0;
    logic [7:0] cpu_din;
    logic       cpu_waitn;
    logic       com_cs = 1'b0, ctrl_cs = 1'b0, nmi_cs = 1'b0;
    logic       irqack_cs = 1'b0, stat_cs = 1'b0;
    logic [8:0] host_AB;
    logic [7:0] host_dout;
    logic       host_we;
    logic [7:0] shared_dout = 8'd0;
    logic       mcu_ban = 1'b0;
    logic       mcu_halt, mcu_nmi_set;
    logic       mcu_irqmain = 1'b0;
    logic       main_irq;

    jtdd_mcu_host #(.NMI_LEN(NMI_LEN), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .cpu_AB(cpu_AB), .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .cpu_waitn(cpu_waitn), .com_cs(com_cs), .ctrl_cs(ctrl_cs), .nmi_cs(nmi_cs),
        .irqack_cs(irqack_cs), .stat_cs(stat_cs), .host_AB(host_AB),
        .host_dout(host_dout), .host_we(host_we), .shared_dout(shared_dout),
        .mcu_ban(mcu_ban), .mcu_halt(mcu_halt), .mcu_nmi_set(mcu_nmi_set),
        .mcu_irqmain(mcu_irqmain), .main_irq(main_irq)
    );

    always #5 clk = ~clk;
    // cen on every other rising edge, changed on the falling edge
    always @(negedge clk) cen <= ~cen;

    // Registered shared RAM, 1 cen read latency
    logic [7:0] ram [512];
    always @(posedge clk) begin
        if (cen) begin
            if (host_we) ram[host_AB] <= host_dout;
            shared_dout <= ram[host_AB];
        end
    end

    // Reference model state
    logic [7:0] shadow [512];
    logic [8:0] written [$];
    bit halt_m, irq_m, to_m, irq_prev;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next enabled clock edge
    task automatic step();
        @(posedge clk);
        while (!cen) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input int sel, input logic [7:0] data);
        ctrl_cs   = (sel == 0);
        nmi_cs    = (sel == 1);
        irqack_cs = (sel == 2);
        cpu_wrn   = 1'b0;
        cpu_dout  = data;
        step();
        if (sel == 0) halt_m = data[0];
        if (sel == 2) irq_m = 1'b0;
        ctrl_cs = 1'b0; nmi_cs = 1'b0; irqack_cs = 1'b0; cpu_wrn = 1'b1;
        step();
    endtask

    task automatic stat_read();
        stat_cs = 1'b1;
        #1;
        check("status", {24'd0, cpu_din}, {29'd0, to_m, halt_m, irq_m});
        step();
        to_m    = 1'b0;
        stat_cs = 1'b0;
    endtask

    // One shared-RAM access with mcu_ban held high for its first k cen cycles
    task automatic access(input bit wr, input logic [8:0] addr, input logic [7:0] data,
                          input int k);
        int  low, we_cnt, we_ban, exp_low;
        bit  done, to;
        to      = TO_EN && (k >= 1) && (k - 1 >= int'(WMAX));
        exp_low = to ? 1 + int'(WMAX) : (wr ? 2 : 3) + k;
        low = 0; we_cnt = 0; we_ban = 0; done = 1'b0;
        cpu_AB = addr; cpu_dout = data; cpu_wrn = !wr; com_cs = 1'b1;
        for (int n = 0; n < 60 && !done; n++) begin
            mcu_ban = (n < k);
            #1;
            if (host_we) begin
                we_cnt++;
                if (mcu_ban) we_ban++;
            end
            if (cpu_waitn) done = 1'b1;
            else begin
                low++;
                step();
            end
        end
        check("acc_done", {31'd0, done}, 32'd1);
        check(wr ? "wr_wait_len" : "rd_wait_len", low, exp_low);
        check("we_pulses", we_cnt, (wr && !to) ? 1 : 0);
        check("we_while_ban", we_ban, 0);
        if (!wr) check("rd_data", {24'd0, cpu_din}, {24'd0, to ? 8'hFF : shadow[addr]});
        if (wr && !to) begin
            shadow[addr] = data;
            written.push_back(addr);
        end
        if (to) to_m = 1'b1;
        com_cs = 1'b0; mcu_ban = 1'b0; cpu_wrn = 1'b1;
        step();
        check("idle_waitn", {31'd0, cpu_waitn}, 32'd1);
        check("idle_din", {24'd0, cpu_din}, 32'd0);
    endtask

    // Trigger NMI at cen 0 and again at cen d (d = 0: single trigger)
    task automatic nmi_test(input int d);
        int hi;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            nmi_cs  = (i == 0) || (i == d);
            cpu_wrn = !nmi_cs;
            step();
            if (mcu_nmi_set) hi++;
        end
        nmi_cs = 1'b0; cpu_wrn = 1'b1;
        check("nmi_len", hi, (d == 0) ? int'(NMI_LEN) : d + int'(NMI_LEN));
    endtask

    task automatic irq_cycle(input bit lvl, input bit ack);
        bit rise;
        mcu_irqmain = lvl;
        irqack_cs   = ack;
        cpu_wrn     = !ack;
        step();
        rise = lvl && !irq_prev;
        if (rise)     irq_m = 1'b1;
        else if (ack) irq_m = 1'b0;
        irq_prev  = lvl;
        irqack_cs = 1'b0;
        cpu_wrn   = 1'b1;
        check("main_irq", {31'd0, main_irq}, {31'd0, irq_m});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] a;
        logic [7:0] v;
        halt_m = 1'b1; irq_m = 1'b0; to_m = 1'b0; irq_prev = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_halt", {31'd0, mcu_halt}, 32'd1);
        check("rst_nmi", {31'd0, mcu_nmi_set}, 32'd0);
        check("rst_irq", {31'd0, main_irq}, 32'd0);
        check("rst_waitn", {31'd0, cpu_waitn}, 32'd1);
        check("rst_we", {31'd0, host_we}, 32'd0);
        check("rst_din", {24'd0, cpu_din}, 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_halt", {31'd0, mcu_halt}, 32'd1);
        stat_read();

        // Release halt
        wr_reg(0, 8'hFE);
        check("halt_rel", {31'd0, mcu_halt}, 32'd0);
        stat_read();

        // Uncontended write/read and a 10-cen contended write
        access(1'b1, 9'h123, 8'h5A, 0);
        access(1'b0, 9'h123, 8'h00, 0);
        access(1'b1, 9'h010, 8'h77, 10);
        access(1'b0, 9'h010, 8'h00, 0);
        stat_read();

        // Random traffic with random contention
        for (int i = 0; i < 40; i++) begin
            int k;
            k = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 0) begin
                a = 9'($urandom_range(0, 511));
                v = 8'($urandom);
                access(1'b1, a, v, k);
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                access(1'b0, a, 8'h00, k);
            end
            if (i % 5 == 4) stat_read();
        end
        stat_read();

        // NMI pulse length, single and retriggered
        nmi_test(0);
        nmi_test(2);
        nmi_test(int'($urandom_range(1, 3)));

        // IRQ set/ack collision, then random traffic
        irq_cycle(1'b0, 1'b0);
        irq_cycle(1'b1, 1'b1);
        check("irq_collide", {31'd0, main_irq}, 32'd1);
        irq_cycle(1'b1, 1'b1);
        check("irq_ack", {31'd0, main_irq}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            irq_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end
        stat_read();

        // Random control writes
        for (int i = 0; i < 4; i++) begin
            wr_reg(0, 8'($urandom));
            check("ctrl_halt", {31'd0, mcu_halt}, {31'd0, halt_m});
            stat_read();
        end

`ifdef JTDD_MCU_HOST_TIMEOUT_EN
        // Read with the bus permanently banned
        a = written[0];
        access(1'b0, a, 8'h00, 30);
        stat_read();
        stat_read();
`endif

        // Reset in the middle of a granted write drops it
        mcu_irqmain = 1'b0;
        wr_reg(0, 8'h00);
        a = written[$urandom_range(0, written.size() - 1)];
        v = shadow[a];
        cpu_AB = a; cpu_dout = ~v; cpu_wrn = 1'b0; com_cs = 1'b1; mcu_ban = 1'b0;
        step();
        check("grant_we", {31'd0, host_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", {31'd0, host_we}, 32'd0);
        check("rst_mid_halt", {31'd0, mcu_halt}, 32'd1);
        com_cs = 1'b0; cpu_wrn = 1'b1;
        step();
        rst_n = 1'b1;
        halt_m = 1'b1; irq_m = 1'b0; to_m = 1'b0; irq_prev = 1'b0;
        step();
        access(1'b0, a, 8'h00, 0);
        stat_read();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
